// File: rtl/nibble_ctrl_pkg.sv
// Shared encodings for the Nibble sequencing controller: FSM state codes and
// the width of the retired-instruction counter.
package nibble_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_WB     = 3'd3,
    S_EXEC   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int OPC_W = 8;

endpackage

// File: rtl/nibble_cycle_cnt.sv
// Phase counter for FETCH/EXEC: clears, holds while stalled, and flags the
// cycle on which the count equals the loaded terminal value.
module nibble_cycle_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_hold,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= i_clr ? '0 : r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/nibble_seq_ctrl.sv
// Nibble datapath sequencer: FETCH -> DECODE -> (WB) -> EXEC -> DONE, with
// chaining from EXEC straight into DECODE, stall freeze and a retire counter.
module nibble_seq_ctrl
  import nibble_ctrl_pkg::*;
#(
  parameter int OP_W         = 3,
  parameter int FETCH_CYCLES = 3,
  parameter int EXEC_CYCLES  = 4,
  parameter int WB_BIT       = 0,
  localparam int MAXC = (FETCH_CYCLES > EXEC_CYCLES) ? FETCH_CYCLES : EXEC_CYCLES,
  localparam int CW   = $clog2((MAXC > 2) ? MAXC : 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic             stall,
  output logic             mux_X,
  output logic             mux_Y,
  output logic             ENA_1,
  output logic             ENA_2,
  output logic             out_we,
  output logic             busy,
  output logic             done,
  output logic [OPC_W-1:0] op_count,
  output logic [2:0]       dbg_state,
  output logic [OP_W-1:0]  dbg_op,
  output logic [CW-1:0]    dbg_cnt
);

  localparam logic [CW-1:0] F_LAST = CW'(FETCH_CYCLES - 1);
  localparam logic [CW-1:0] E_LAST = CW'(EXEC_CYCLES - 1);

  state_t            r_state;
  logic [OP_W-1:0]   r_op_q;
  logic [OPC_W-1:0]  r_op_count;
  logic              r_ena1, r_ena2, r_we, r_busy, r_done;

  state_t            w_next;
  logic [OP_W-1:0]   w_op_next;
  logic              w_retire;
  logic              w_hold;
  logic              w_cnt_clr;
  logic [CW-1:0]     w_last;
  logic [CW-1:0]     w_cnt;
  logic              w_tc;

  assign w_hold    = stall && (r_state inside {S_FETCH, S_DECODE, S_WB, S_EXEC});
  assign w_cnt_clr = !(r_state inside {S_FETCH, S_EXEC}) || w_tc;
  assign w_last    = (r_state == S_FETCH) ? F_LAST : E_LAST;

  nibble_cycle_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cnt_clr),
    .i_hold (w_hold),
    .i_last (w_last),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_next    = r_state;
    w_op_next = r_op_q;
    w_retire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next    = S_FETCH;
          w_op_next = op;
        end
      end
      S_FETCH:  if (!stall && w_tc) w_next = S_DECODE;
      S_DECODE: if (!stall) w_next = r_op_q[WB_BIT] ? S_WB : S_EXEC;
      S_WB:     if (!stall) w_next = S_EXEC;
      S_EXEC: begin
        if (!stall && w_tc) begin
          w_retire = 1'b1;
          if (start) begin
            w_next    = S_DECODE;
            w_op_next = op;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output flags are decoded from the next state so they are registered
  // alongside it; only the stall gating is applied combinationally.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op_q     <= '0;
      r_op_count <= '0;
      r_ena1     <= 1'b0;
      r_ena2     <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_op_q  <= w_op_next;
      if (w_retire && (r_op_count != '1)) begin
        r_op_count <= r_op_count + OPC_W'(1);
      end
      r_ena1 <= (w_next == S_FETCH);
      r_ena2 <= (w_next == S_WB) || (w_next == S_EXEC);
      r_we   <= (w_next == S_WB);
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
    end
  end

  assign mux_X     = r_op_q[1];
  assign mux_Y     = r_op_q[0];
  assign ENA_1     = r_ena1 && !stall;
  assign ENA_2     = r_ena2 && !stall;
  assign out_we    = r_we && !stall;
  assign busy      = r_busy;
  assign done      = r_done;
  assign op_count  = r_op_count;
  assign dbg_state = r_state;
  assign dbg_op    = r_op_q;
  assign dbg_cnt   = w_cnt;

endmodule

// File: tb/tb_nibble_seq_ctrl.sv
// Directed bench for nibble_seq_ctrl at default parameters. Inputs change and
// outputs are sampled just after the rising edge; the DUT updates on falling.
module tb_nibble_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic       stall = 1'b0;
  logic       mux_X, mux_Y, ENA_1, ENA_2, out_we, busy, done;
  logic [7:0] op_count;
  logic [2:0] dbg_state;
  logic [2:0] dbg_op;
  logic [1:0] dbg_cnt;
  logic [6:0] obs;

  int n_pass = 0;
  int n_total = 0;

  // obs = {busy, ENA_1, ENA_2, out_we, done, mux_X, mux_Y}
  assign obs = {busy, ENA_1, ENA_2, out_we, done, mux_X, mux_Y};

  always #5 clk = ~clk;

  nibble_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .stall     (stall),
    .mux_X     (mux_X),
    .mux_Y     (mux_Y),
    .ENA_1     (ENA_1),
    .ENA_2     (ENA_2),
    .out_we    (out_we),
    .busy      (busy),
    .done      (done),
    .op_count  (op_count),
    .dbg_state (dbg_state),
    .dbg_op    (dbg_op),
    .dbg_cnt   (dbg_cnt)
  );

  task automatic test_reset();
    #1;
    n_total++;
    if (obs !== 7'b0 || op_count !== 8'd0 || dbg_state !== 3'd0) begin
      $display("FAIL reset_init: obs=%b cnt=%0d st=%0d want 0/0/0", obs, op_count, dbg_state);
    end else n_pass++;
    @(posedge clk); start = 1'b1; op = 3'b111; #1;
    n_total++;
    if (obs !== 7'b0) $display("FAIL reset_hold_start: obs=%b want 0000000", obs);
    else n_pass++;
    @(posedge clk); reset = 1'b0; start = 1'b0; #1;
    @(posedge clk); #1;
    n_total++;
    if (obs !== 7'b0 || dbg_state !== 3'd0) begin
      $display("FAIL reset_release_idle: obs=%b st=%0d want 0000000/0", obs, dbg_state);
    end else n_pass++;
  endtask

  task automatic test_single_wb();
    logic [6:0] exp_v [11];
    exp_v = '{7'b1100011, 7'b1100011, 7'b1100011, 7'b1000011, 7'b1011011,
              7'b1010011, 7'b1010011, 7'b1010011, 7'b1010011, 7'b1000111,
              7'b0000011};
    @(posedge clk); start = 1'b1; op = 3'b011;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); start = 1'b0; op = 3'b000; #1;
      n_total++;
      if (obs !== exp_v[i]) $display("FAIL single_wb cyc %0d: obs=%b want %b", i, obs, exp_v[i]);
      else n_pass++;
    end
    n_total++;
    if (op_count !== 8'd1) $display("FAIL single_wb_count: got %0d want 1", op_count);
    else n_pass++;
  endtask

  task automatic test_single_nowb();
    logic [6:0] exp_v [10];
    exp_v = '{7'b1100010, 7'b1100010, 7'b1100010, 7'b1000010, 7'b1010010,
              7'b1010010, 7'b1010010, 7'b1010010, 7'b1000110, 7'b0000010};
    @(posedge clk); start = 1'b1; op = 3'b010;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); start = 1'b0; #1;
      n_total++;
      if (obs !== exp_v[i]) $display("FAIL single_nowb cyc %0d: obs=%b want %b", i, obs, exp_v[i]);
      else n_pass++;
    end
    n_total++;
    if (op_count !== 8'd2) $display("FAIL single_nowb_count: got %0d want 2", op_count);
    else n_pass++;
  endtask

  task automatic test_chain();
    logic [6:0] exp_v [16];
    exp_v = '{7'b1100001, 7'b1100001, 7'b1100001, 7'b1000001, 7'b1011001,
              7'b1010001, 7'b1010001, 7'b1010001, 7'b1010001, 7'b1000000,
              7'b1010000, 7'b1010000, 7'b1010000, 7'b1010000, 7'b1000100,
              7'b0000000};
    @(posedge clk); start = 1'b1; op = 3'b001;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); start = (i <= 8); op = 3'b000; #1;
      n_total++;
      if (obs !== exp_v[i]) $display("FAIL chain cyc %0d: obs=%b want %b", i, obs, exp_v[i]);
      else n_pass++;
    end
    n_total++;
    if (op_count !== 8'd4) $display("FAIL chain_count: got %0d want 4", op_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [6:0] exp_v [12];
    exp_v = '{7'b1100010, 7'b1000010, 7'b1000010, 7'b1100010, 7'b1100010,
              7'b1000010, 7'b1010010, 7'b1010010, 7'b1010010, 7'b1010010,
              7'b1000110, 7'b0000010};
    @(posedge clk); start = 1'b1; op = 3'b110;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); start = 1'b0; stall = (i == 1 || i == 2);
      op = (i == 1 || i == 2) ? 3'b001 : 3'b110;
      #1;
      n_total++;
      if (obs !== exp_v[i]) $display("FAIL stall cyc %0d: obs=%b want %b", i, obs, exp_v[i]);
      else n_pass++;
    end
    stall = 1'b0;
    n_total++;
    if (op_count !== 8'd5) $display("FAIL stall_count: got %0d want 5", op_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); start = 1'b1; op = 3'b011;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); start = 1'b0; #1;
      if (i == 5) begin
        n_total++;
        if (obs !== 7'b1010011) $display("FAIL reset_mid_exec: obs=%b want 1010011", obs);
        else n_pass++;
      end
    end
    n_total++;
    if (op_count !== 8'd5) $display("FAIL reset_mid_precount: got %0d want 5", op_count);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (obs !== 7'b0 || op_count !== 8'd0 || dbg_state !== 3'd0) begin
      $display("FAIL reset_mid_async: obs=%b cnt=%0d st=%0d want 0/0/0", obs, op_count, dbg_state);
    end else n_pass++;
    @(posedge clk); reset = 1'b0; #1;
    @(posedge clk); #1;
    n_total++;
    if (obs !== 7'b0 || dbg_state !== 3'd0) begin
      $display("FAIL reset_mid_idle: obs=%b st=%0d want 0000000/0", obs, dbg_state);
    end else n_pass++;
  endtask

  task automatic test_saturation();
    int done_cyc = -1;
    @(posedge clk); start = 1'b1; op = 3'b000;
    for (int c = 1; c <= 1310; c++) begin
      @(posedge clk); start = (c < 1303); #1;
      if (c == 1274) begin
        n_total++;
        if (op_count !== 8'd254) $display("FAIL sat_mid_count: got %0d want 254", op_count);
        else n_pass++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    n_total++;
    if (done_cyc != 1304) $display("FAIL sat_done_cycle: got %0d want 1304", done_cyc);
    else n_pass++;
    n_total++;
    if (op_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", op_count);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_wb();
    test_single_nowb();
    test_chain();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nibble_seq_ctrl.md
# nibble_seq_ctrl

Parametrised sequencing control unit for the Nibble datapath. It is the next generation of the fixed 8-state controller. It latches an opcode on a start handshake and runs a configurable fetch phase, a decode cycle, an optional write-back cycle and a configurable execute phase. It then either chains straight into the next instruction or reports done. It drives the datapath operand muxes, the two register-bank enables and the output write-enable, and adds stall support and a retired-instruction counter.

## Interface
- OP_W, 3, opcode width; legal range ≥ 2
- FETCH_CYCLES, 3, cycles spent in FETCH; legal range ≥ 1
- EXEC_CYCLES, 4, cycles spent in EXEC; legal range ≥ 1
- WB_BIT, 0, opcode bit index that requests write-back; must be < OP_W
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to begin or chain an instruction
- op  in  OP_W  opcode, sampled together with start
- stall  in  1  freezes sequencing while high
- mux_X  out  1  operand X select = op_q[1]
- mux_Y  out  1  operand Y select = op_q[0]
- ENA_1  out  1  bank-1 enable
- ENA_2  out  1  bank-2 enable
- out_we  out  1  output-register write-enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- op_count  out  8  retired instructions; saturating

## Operation
- States: IDLE, FETCH, DECODE, WB, EXEC, DONE.
- Internal registers: op_q (OP_W bits), cycle counter cnt, op_count.
- IDLE
  - If start=1: op_q←op, cnt←0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH
  - ENA_1=1.
  - cnt increments each cycle.
  - When cnt=FETCH_CYCLES-1: go to DECODE, cnt←0.
- DECODE
  - One cycle, no enables.
  - If op_q[WB_BIT]=1, go to WB; otherwise go to EXEC.
- WB
  - One cycle: out_we=1, ENA_2=1.
  - Then go to EXEC, cnt←0.
- EXEC
  - ENA_2=1.
  - cnt increments each cycle.
  - On the cycle where cnt=EXEC_CYCLES-1:
    - op_count increments; it saturates at 255.
    - If start=1: op_q←op and go to DECODE. Chaining skips FETCH.
    - If start=0: go to DONE.
- DONE
  - done=1 for one cycle, then go to IDLE.
  - start is ignored in DONE.
- stall=1 in FETCH, DECODE, WB or EXEC:
  - State, cnt, op_q and op_count hold.
  - ENA_1, ENA_2 and out_we are forced to 0.
  - EXEC end-of-phase actions, including sampling start, do not occur while stalled.
- stall has no effect in IDLE or DONE.
- mux_X and mux_Y come from op_q, never from the live op input.
- Reset, asynchronous and mid-operation included:
  - Next state is IDLE.
  - op_q, cnt and op_count are cleared to 0.
  - Every output is 0: mux_X, mux_Y, ENA_1, ENA_2, out_we, busy, done, op_count.

## Timing
- Registers update on the falling edge of clk.
- Outputs are Moore decodes of state and op_q, gated combinationally by stall. They are valid from the falling edge until the next falling edge.
- start and op are sampled at the falling edge.
- Unstalled latency, counted from the first FETCH cycle through the DONE cycle inclusive: FETCH_CYCLES + 1 + (1 if write-back) + EXEC_CYCLES + 1. Defaults give 10 cycles with WB and 9 without.
- Each chained instruction costs 1 + (1 if write-back) + EXEC_CYCLES cycles.
- cnt width is $clog2(max(FETCH_CYCLES, EXEC_CYCLES, 2)).
- With FETCH_CYCLES=1 or EXEC_CYCLES=1 the phase lasts exactly one cycle.
- op_count at 255 stays 255 on further retirements.

## Structure
- Shared package nibble_ctrl_pkg holds:
  - the 3-bit state encodings: IDLE=0, FETCH=1, DECODE=2, WB=3, EXEC=4, DONE=5;
  - the op_count width constant (8).
- Unused encodings 6 and 7 recover to IDLE on the next edge.
- One sub-module: nibble_cycle_cnt, a loadable phase counter with clear, hold (stall) and terminal-count output, parametrised by width.

## Test plan
- **Reset:** assert reset mid-EXEC → all outputs 0 immediately; IDLE after release; op_count=0.
- **Single instruction with WB (defaults):** op=3'b011 with one-cycle start pulse → ENA_1 for 3 cycles, 1 DECODE cycle, 1 cycle of out_we=ENA_2=1, ENA_2 for 4 cycles, then done pulse; mux_X=1, mux_Y=1; op_count=1.
- **Single instruction without WB:** op=3'b010 → no out_we cycle; done arrives 9 cycles after FETCH entry; mux_X=1, mux_Y=0.
- **Chaining:** hold start=1 with op=3'b001 then 3'b000 → second instruction enters DECODE directly after the last EXEC cycle with no FETCH; single done pulse at the end; op_count=2.
- **Stall:** stall=1 for 2 cycles in the second FETCH cycle → ENA_1 low during the stall; FETCH lasts 5 cycles total; op changes during the stall do not affect mux_X/mux_Y.
- **Saturation:** 260 chained instructions → op_count reads 255.
